// File: rtl/rom_rd_pkg.sv
// Shared definitions for the ROM read controller: state encodings, default
// bus widths, wait-counter width and the ROM access time.
`timescale 1ns/1ps

package rom_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  // Wide enough for the largest legal wait count (15).
  localparam int CNT_W = 4;

  // Access time of the asynchronous ROM, address/oeb to valid data.
  localparam int ROM_RDELAY_PS = 1500;

endpackage

// File: rtl/rom_reader.sv
// Synchronous read controller for a 16x8 asynchronous ROM.
// Accepts one-word requests in IDLE, holds rom_addr/rom_oeb for WAIT_CYC
// edges, registers rom_data and returns it with a one-cycle rd_valid pulse,
// then spends one RECOVER cycle with rom_oeb high for bus turnaround.
// Optional build macro ROM_RD_AUTOINC_EN adds req_next, which reads the word
// after the last address (wrapping at the top of the ROM).
`timescale 1ns/1ps

module rom_reader
  import rom_rd_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_oeb,
  input  logic [DATA_W-1:0] rom_data
`ifdef ROM_RD_AUTOINC_EN
  ,
  input  logic              req_next
`endif
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               start;
  logic [ADDR_W-1:0]  start_addr;

  // Decide whether a read starts this cycle and from which address.
  // NOTE: every output of an always_comb gets a default first, otherwise a
  // path that skips the assignment infers a latch.
  always_comb begin
    start      = req;
    start_addr = req_addr;
`ifdef ROM_RD_AUTOINC_EN
    if (!req && req_next) begin
      start      = 1'b1;
      start_addr = rom_addr + ADDR_W'(1);
    end
`endif
  end

  // Access FSM with wait counter; every ROM-facing output is registered.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rom_oeb  <= 1'b1;
      rom_addr <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      cnt      <= '0;
    end else begin
      rd_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr <= start_addr;
            rom_oeb  <= 1'b0;
            cnt      <= CNT_W'(WAIT_CYC - 1);
            state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            rd_data  <= rom_data;
            rd_valid <= 1'b1;
            rom_oeb  <= 1'b1;
            state    <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule
